mlu_lookahead_loader: RTL and testbench

- Boot-time writer for the MLU carry-lookahead SRAM (sram17x8).
- On START, walks all 2^17 addresses. At each address it computes the 8-bit ripple-carry result and writes it with async-SRAM timing (address setup, N_WE pulse, hold).
- Sits between reset/boot control and the lookahead SRAM. The ALU path reads the SRAM only after DONE.

---
 rtl/mlu_pkg.sv | 30 +++
 rtl/mlu_carry_chain.sv | 19 +
 rtl/mlu_lookahead_loader.sv | 185 ++++++++++++++++++
 tb/tb_mlu_lookahead_loader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mlu_pkg.sv
// Shared definitions for the MLU carry-lookahead table loader and its carry chain.
package mlu_pkg;

    localparam int MLU_LUT_ADDR_W = 17;
    localparam int MLU_LUT_DATA_W = 8;

    // Bit positions of the {C_IN, G[7:0], P[7:0]} fields inside a table address
    localparam int P_LSB   = 0;
    localparam int G_LSB   = 8;
    localparam int CIN_BIT = 16;

    localparam logic [MLU_LUT_ADDR_W-1:0] MLU_LUT_LAST = 17'h1FFFF;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WRITE,
        HOLD,
        VERIFY,
        DONE
    } loader_state_t;

    // Width of a down-counter that must hold values up to max(a, b) - 1
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/mlu_carry_chain.sv
// Ripple-carry function of one lookahead table address {C_IN, G, P} -> 8 carry outputs.
module mlu_carry_chain
    import mlu_pkg::*;
(
    input  logic [MLU_LUT_ADDR_W-1:0] addr,
    output logic [MLU_LUT_DATA_W-1:0] carry
);

    always_comb begin
        logic c;
        carry = '0;
        c     = addr[CIN_BIT];
        for (int i = 0; i < MLU_LUT_DATA_W; i++) begin
            c        = (c & addr[P_LSB + i]) | addr[G_LSB + i];
            carry[i] = c;
        end
    end

endmodule

// File: rtl/mlu_lookahead_loader.sv
// Boot-time writer filling the MLU carry-lookahead SRAM using async write timing.
// Defining MLU_LOADER_VERIFY_EN adds a read-back verify pass that drives ERROR.
//
// state  | meaning
// IDLE   | waiting for START after reset
// SETUP  | ADDR/IN_DATA stable, N_WE high, SETUP_CYCLES long
// WRITE  | N_WE low for WE_CYCLES
// HOLD   | one cycle N_WE high, ADDR/IN_DATA held
// VERIFY | read-back: two cycles N_OE low, compare, one cycle N_OE high
// DONE   | table complete, ADDR parked at the last word
module mlu_lookahead_loader
    import mlu_pkg::*;
#(
    parameter int SETUP_CYCLES = 1,
    parameter int WE_CYCLES    = 2,
    parameter logic [MLU_LUT_ADDR_W-1:0] LAST_ADDR = MLU_LUT_LAST
) (
    input  logic                      CLK,
    input  logic                      N_RST,
    input  logic                      START,
    output logic [MLU_LUT_ADDR_W-1:0] ADDR,
    output logic [MLU_LUT_DATA_W-1:0] IN_DATA,
    input  logic [MLU_LUT_DATA_W-1:0] OUT_DATA,
    output logic                      N_WE,
    output logic                      N_OE,
    output logic                      BUSY,
    output logic                      DONE,
    output logic                      ERROR
);

    localparam int TMR_W = timer_width(SETUP_CYCLES, WE_CYCLES);
    localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(SETUP_CYCLES - 1);
    localparam logic [TMR_W-1:0] WE_LOAD    = TMR_W'(WE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
    localparam logic [MLU_LUT_ADDR_W-1:0] ADDR_ONE = MLU_LUT_ADDR_W'(1);

    loader_state_t               state, state_nx;
    logic [MLU_LUT_ADDR_W-1:0]   addr, addr_nx;
    logic [TMR_W-1:0]            timer, timer_nx;
    logic [MLU_LUT_DATA_W-1:0]   carry;
    logic                        last;

`ifdef MLU_LOADER_VERIFY_EN
    logic [1:0] vphase, vphase_nx;
    logic       error, error_nx;
`else
    logic       unused_out_data;
    assign unused_out_data = ^OUT_DATA;
`endif

    mlu_carry_chain u_carry (
        .addr  (addr),
        .carry (carry)
    );

    // Terminal compare on the address itself; the counter never wraps
    assign last = (addr == LAST_ADDR);

    always_ff @(posedge CLK) begin
        if (!N_RST) begin
            state  <= IDLE;
            addr   <= '0;
            timer  <= '0;
`ifdef MLU_LOADER_VERIFY_EN
            vphase <= '0;
            error  <= 1'b0;
`endif
        end else begin
            state  <= state_nx;
            addr   <= addr_nx;
            timer  <= timer_nx;
`ifdef MLU_LOADER_VERIFY_EN
            vphase <= vphase_nx;
            error  <= error_nx;
`endif
        end
    end

    always_comb begin
        state_nx  = state;
        addr_nx   = addr;
        timer_nx  = timer;
`ifdef MLU_LOADER_VERIFY_EN
        vphase_nx = vphase;
        error_nx  = error;
`endif
        case (state)
            IDLE, mlu_pkg::DONE: begin
                if (START) begin
                    state_nx = SETUP;
                    addr_nx  = '0;
                    timer_nx = SETUP_LOAD;
`ifdef MLU_LOADER_VERIFY_EN
                    error_nx = 1'b0;
`endif
                end
            end
            SETUP: begin
                if (timer == '0) begin
                    state_nx = WRITE;
                    timer_nx = WE_LOAD;
                end else begin
                    timer_nx = timer - TMR_ONE;
                end
            end
            WRITE: begin
                if (timer == '0) begin
                    state_nx = HOLD;
                end else begin
                    timer_nx = timer - TMR_ONE;
                end
            end
            HOLD: begin
                if (!last) begin
                    state_nx = SETUP;
                    addr_nx  = addr + ADDR_ONE;
                    timer_nx = SETUP_LOAD;
                end else begin
`ifdef MLU_LOADER_VERIFY_EN
                    state_nx  = VERIFY;
                    addr_nx   = '0;
                    vphase_nx = '0;
`else
                    state_nx  = mlu_pkg::DONE;
`endif
                end
            end
`ifdef MLU_LOADER_VERIFY_EN
            VERIFY: begin
                case (vphase)
                    2'd0: vphase_nx = 2'd1;
                    2'd1: begin
                        // OUT_DATA has had two full N_OE-low cycles to settle
                        vphase_nx = 2'd2;
                        if (OUT_DATA != carry) begin
                            error_nx = 1'b1;
                        end
                    end
                    default: begin
                        vphase_nx = 2'd0;
                        if (last) begin
                            state_nx = mlu_pkg::DONE;
                        end else begin
                            addr_nx = addr + ADDR_ONE;
                        end
                    end
                endcase
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        N_WE = 1'b1;
        N_OE = 1'b1;
        BUSY = 1'b0;
        DONE = 1'b0;
        case (state)
            SETUP, HOLD: BUSY = 1'b1;
            WRITE: begin
                BUSY = 1'b1;
                N_WE = 1'b0;
            end
`ifdef MLU_LOADER_VERIFY_EN
            VERIFY: begin
                BUSY = 1'b1;
                N_OE = (vphase == 2'd2);
            end
`endif
            mlu_pkg::DONE: DONE = 1'b1;
            default: ;
        endcase
    end

    assign ADDR    = addr;
    assign IN_DATA = carry;

`ifdef MLU_LOADER_VERIFY_EN
    assign ERROR = error;
`else
    assign ERROR = 1'b0;
`endif

endmodule

// File: tb/tb_mlu_lookahead_loader.sv
// Scoreboard bench for mlu_lookahead_loader; the table is shortened via LAST_ADDR to keep loads brief.
module tb_mlu_lookahead_loader;
    import mlu_pkg::*;

    localparam logic [16:0] LAST       = 17'h003FF;
    localparam int          WORDS      = 1024;
    localparam logic [16:0] RST_AT     = 17'h001A5;
    localparam logic [16:0] CORRUPT_AT = 17'h00345;
`ifdef MLU_LOADER_VERIFY_EN
    localparam int          WORD_CYC   = 7;
    localparam logic        VERIFY_ON  = 1'b1;
`else
    localparam int          WORD_CYC   = 4;
    localparam logic        VERIFY_ON  = 1'b0;
`endif
    localparam int          LIMIT      = WORDS * WORD_CYC + 200;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        start = 1'b0;
    logic [16:0] addr;
    logic [7:0]  in_data;
    logic [7:0]  out_data;
    logic        n_we, n_oe, busy, done, error;

    logic [16:0] g_addr = '0;
    logic [7:0]  g_carry;

    always #5 clk = ~clk;

    mlu_lookahead_loader #(
        .SETUP_CYCLES (1),
        .WE_CYCLES    (2),
        .LAST_ADDR    (LAST)
    ) dut (
        .CLK      (clk),
        .N_RST    (n_rst),
        .START    (start),
        .ADDR     (addr),
        .IN_DATA  (in_data),
        .OUT_DATA (out_data),
        .N_WE     (n_we),
        .N_OE     (n_oe),
        .BUSY     (busy),
        .DONE     (done),
        .ERROR    (error)
    );

    mlu_carry_chain golden (
        .addr  (g_addr),
        .carry (g_carry)
    );

    typedef struct packed {
        logic [16:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_w;
    logic [7:0]  mem [0:WORDS-1];
    logic        corrupt = 1'b0;
    logic        mon_en = 1'b0;
    logic        prev_nwe = 1'b1;
    logic [16:0] prev_addr = '0;
    logic [7:0]  prev_data = '0;
    int          checks = 0;
    int          failures = 0;
    int          falls = 0;
    int          proto_err = 0;
    int          cyc_cnt = 0;

    assign out_data = n_oe ? 8'h00 : mem[addr[9:0]];

    function automatic logic [7:0] carry_f(input logic [16:0] a);
        logic       c;
        logic [7:0] r;
        c = a[16];
        r = '0;
        for (int i = 0; i < 8; i++) begin
            c    = (c & a[i]) | a[8 + i];
            r[i] = c;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc_cnt++;
    endtask

    task automatic push_all();
        for (int a = 0; a < WORDS; a++) begin
            exp_q.push_back({17'(a), carry_f(17'(a))});
        end
    endtask

    task automatic wait_done(input string name);
        while (!done && cyc_cnt < LIMIT) step();
        if (!done) chk({name, "_timeout"}, 32'(cyc_cnt), 32'(WORDS * WORD_CYC));
    endtask

    task automatic end_of_load(input string name, input logic exp_err);
        chk({name, "_busy_cycles"}, 32'(cyc_cnt), 32'(WORDS * WORD_CYC));
        chk({name, "_we_falls"}, 32'(falls), 32'(WORDS));
        chk({name, "_sb_left"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_done"}, {30'd0, busy, done}, 32'd1);
        chk({name, "_addr_last"}, 32'(addr), 32'(LAST));
        chk({name, "_strobes"}, {30'd0, n_we, n_oe}, 32'd3);
        chk({name, "_error"}, 32'(error), 32'(exp_err));
        chk({name, "_protocol"}, 32'(proto_err), 32'd0);
    endtask

    // SRAM model, write scoreboard and protocol watch
    always @(negedge clk) begin
        if (mon_en) begin
            if (!n_we && (addr !== prev_addr || in_data !== prev_data)) proto_err++;
            if (!n_we && !n_oe) proto_err++;
            if (prev_nwe && !n_we) falls++;
            if (!prev_nwe && n_we && busy) begin
                mem[addr[9:0]] = (corrupt && addr == CORRUPT_AT) ? (in_data ^ 8'hFF) : in_data;
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_write", 32'(addr), 32'h0);
                end else begin
                    mon_w = exp_q.pop_front();
                    chk("sb_addr", 32'(addr), 32'(mon_w.a));
                    chk("sb_data", 32'(in_data), 32'(mon_w.d));
                end
            end
        end
        prev_nwe  = n_we;
        prev_addr = addr;
        prev_data = in_data;
    end

    logic [16:0] hv_a [7] = '{17'h100FF, 17'h00100, 17'h001FF, 17'h10001, 17'h10000, 17'h000FF, 17'h12345};
    logic [7:0]  hv_d [7] = '{8'hFF, 8'h01, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h67};

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = 8'h00;

        // reset values
        repeat (3) step();
        chk("rst_addr", 32'(addr), 32'h0);
        chk("rst_in_data", 32'(in_data), 32'h0);
        chk("rst_strobes", {30'd0, n_we, n_oe}, 32'd3);
        chk("rst_flags", {29'd0, busy, done, error}, 32'd0);
        n_rst = 1'b1;
        step();
        mon_en = 1'b1;

        // carry chain against hand-computed vectors
        for (int i = 0; i < 7; i++) begin
            g_addr = hv_a[i];
            #1;
            chk($sformatf("carry_%05h", hv_a[i]), 32'(g_carry), 32'(hv_d[i]));
        end

        // load 1: start timing, ignored STARTs while busy
        push_all();
        falls = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc_cnt = 0;
        chk("l1_busy_rise", {30'd0, busy, done}, 32'd2);
        chk("l1_addr0", 32'(addr), 32'h0);
        chk("l1_data0", 32'(in_data), 32'h0);
        chk("l1_setup_we_high", 32'(n_we), 32'd1);
        step();
        chk("l1_we_low_c1", 32'(n_we), 32'd0);
        step();
        chk("l1_we_low_c2", 32'(n_we), 32'd0);
        step();
        chk("l1_hold_we_high", 32'(n_we), 32'd1);
        chk("l1_hold_addr", 32'(addr), 32'h0);
        step();
        chk("l1_next_addr", 32'(addr), 32'h1);
        for (int k = 0; k < 3; k++) begin
            repeat (37) step();
            start = 1'b1;
            step();
            start = 1'b0;
        end
        wait_done("l1");
        end_of_load("l1", 1'b0);
        chk("mem_00100", 32'(mem[10'h100]), 32'h01);
        chk("mem_001FF", 32'(mem[10'h1FF]), 32'hFF);
        chk("mem_000FF", 32'(mem[10'h0FF]), 32'h00);
        chk("mem_00000", 32'(mem[10'h000]), 32'h00);
        chk("mem_003FF", 32'(mem[10'h3FF]), 32'hFF);

        // load 2: START held in DONE restarts; SRAM corrupts one word
        corrupt = VERIFY_ON;
        push_all();
        falls = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc_cnt = 0;
        chk("l2_restart", {30'd0, busy, done}, 32'd2);
        chk("l2_addr0", 32'(addr), 32'h0);
        chk("l2_error_clr", 32'(error), 32'd0);
        wait_done("l2");
        end_of_load("l2", VERIFY_ON);
        corrupt = 1'b0;

        // load 3: reset mid-WRITE, then a clean reload
        push_all();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("l3_error_clr", 32'(error), 32'd0);
        while (!(addr == RST_AT && !n_we) && cyc_cnt < 4 * LIMIT) step();
        chk("l3_reached_write", {15'd0, addr}, {15'd0, RST_AT});
        n_rst = 1'b0;
        step();
        chk("l3_rst_we", 32'(n_we), 32'd1);
        chk("l3_rst_flags", {29'd0, busy, done, error}, 32'd0);
        chk("l3_rst_addr", 32'(addr), 32'h0);
        exp_q.delete();
        n_rst = 1'b1;
        step();
        push_all();
        falls = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc_cnt = 0;
        wait_done("l3");
        end_of_load("l3", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
